// File: rtl/btn_debouncer_multi.sv
// btn_debouncer_multi: per-channel synchronise+debounce of btn_in (clk_in, sync rst_in) to btn_out with rise_out/fall_out/repeat_out pulses and clr_in-cleared press_pending_out; auto-repeat built only under BTN_DEBOUNCE_REPEAT_EN
module btn_debouncer_multi #(
  parameter int NUM_BTNS = 4,
  parameter int DEBOUNCE_CLOCKS = 10,
  parameter int SYNC_STAGES = 2,
  parameter logic [NUM_BTNS-1:0] ACTIVE_LOW_MASK = '0,
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [NUM_BTNS-1:0] btn_in,
  input  logic [NUM_BTNS-1:0] clr_in,
  output logic [NUM_BTNS-1:0] btn_out,
  output logic [NUM_BTNS-1:0] rise_out,
  output logic [NUM_BTNS-1:0] fall_out,
  output logic [NUM_BTNS-1:0] repeat_out,
  output logic [NUM_BTNS-1:0] press_pending_out
);
  localparam int CW = $clog2(DEBOUNCE_CLOCKS + 1);
  logic [NUM_BTNS-1:0] sync_q [SYNC_STAGES];
  logic [NUM_BTNS-1:0] sync;
  logic [NUM_BTNS-1:0] out_next;
  assign sync = sync_q[SYNC_STAGES-1];
  always_ff @(posedge clk_in)
    if (rst_in) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= btn_in ^ ACTIVE_LOW_MASK;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
    logic [CW-1:0] cnt;
    logic done;
    assign done = sync[i] != btn_out[i] && cnt == CW'(DEBOUNCE_CLOCKS - 1);
    assign out_next[i] = done ? sync[i] : btn_out[i];
    always_ff @(posedge clk_in)
      cnt <= (rst_in || done || sync[i] == btn_out[i]) ? '0 : cnt + 1'b1;
`ifdef BTN_DEBOUNCE_REPEAT_EN
    localparam int HW = $clog2((REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD) + 1);
    logic [HW-1:0] hold;
    logic first, rep, held, fire;
    // held excludes the rise edge and the fall edge, so repeat never lands on either pulse
    assign held = btn_out[i] & out_next[i];
    assign fire = held && hold == (first ? HW'(REPEAT_DELAY - 1) : HW'(REPEAT_PERIOD - 1));
    always_ff @(posedge clk_in)
      if (rst_in || !held) begin
        hold <= '0;
        first <= 1'b1;
        rep <= 1'b0;
      end else begin
        hold <= fire ? '0 : hold + 1'b1;
        first <= first & ~fire;
        rep <= fire;
      end
    assign repeat_out[i] = rep;
`else
    assign repeat_out[i] = 1'b0;
`endif
  end
  // flag sets from the registered pulses, so a clear in the pulse cycle loses to the set
  always_ff @(posedge clk_in)
    if (rst_in) begin
      btn_out <= '0;
      rise_out <= '0;
      fall_out <= '0;
      press_pending_out <= '0;
    end else begin
      btn_out <= out_next;
      rise_out <= out_next & ~btn_out;
      fall_out <= ~out_next & btn_out;
      press_pending_out <= rise_out | repeat_out | (press_pending_out & ~clr_in);
    end
endmodule

// File: tb/tb_btn_debouncer_multi.sv
// tb_btn_debouncer_multi: table-driven and scoreboard checks of btn_debouncer_multi
module tb_btn_debouncer_multi;
  logic clk_in = 1'b0;
  logic rst_in;
  logic [3:0] btn_in, clr_in;
  logic [3:0] btn_out, rise_out, fall_out, repeat_out, press_pending_out;
  btn_debouncer_multi #(
    .NUM_BTNS(4), .DEBOUNCE_CLOCKS(4), .SYNC_STAGES(2), .ACTIVE_LOW_MASK(4'b0100),
    .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .btn_in(btn_in), .clr_in(clr_in),
    .btn_out(btn_out), .rise_out(rise_out), .fall_out(fall_out),
    .repeat_out(repeat_out), .press_pending_out(press_pending_out)
  );
  always #5 clk_in = ~clk_in;
  typedef struct {
    logic rst;
    logic [3:0] btn, clr, lvl, rise, fall, pp;
  } vec_t;
  vec_t vecs[$];
  logic [19:0] exp_q[$];
  int rep_q[$];
  int checks = 0;
  int fails = 0;
  function automatic void add(int n, logic rst, logic [3:0] btn, logic [3:0] clr,
                              logic [3:0] lvl, logic [3:0] rise, logic [3:0] fall, logic [3:0] pp);
    vec_t v;
    v.rst = rst; v.btn = btn; v.clr = clr; v.lvl = lvl; v.rise = rise; v.fall = fall; v.pp = pp;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endfunction
  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask
  initial begin
    int rise_t, rises;
    // reset, channel 2 is active-low so its idle raw level is 1
    add(3, 1, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    // clean press / release ch0
    add(5, 0, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1, 0, 4'b0101, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    add(1, 0, 4'b0101, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    add(5, 0, 4'b0100, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    add(1, 0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
    add(1, 0, 4'b0100, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    // bounce on ch1 then stable press
    add(2, 0, 4'b0110, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(2, 0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(2, 0, 4'b0110, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(2, 0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(5, 0, 4'b0110, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1, 0, 4'b0110, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0000);
    add(3, 0, 4'b0110, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0010);
    add(5, 0, 4'b0100, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0010);
    add(1, 0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0010);
    add(1, 0, 4'b0100, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    // active-low ch2
    add(5, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1, 0, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0000);
    add(1, 0, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
    add(5, 0, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
    add(1, 0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
    add(1, 0, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    // ch3 sticky flag: clear on empty flag, clear colliding with set, clear alone
    add(4, 0, 4'b1100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1, 0, 4'b1100, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1, 0, 4'b1100, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0000);
    add(1, 0, 4'b1100, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b1000);
    add(1, 0, 4'b1100, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000);
    add(5, 0, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000);
    add(1, 0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000);
    add(1, 0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    // simultaneous ch0+ch1
    add(5, 0, 4'b0111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1, 0, 4'b0111, 4'b0000, 4'b0011, 4'b0011, 4'b0000, 4'b0000);
    add(1, 0, 4'b0111, 4'b0000, 4'b0011, 4'b0000, 4'b0000, 4'b0011);
    add(5, 0, 4'b0100, 4'b0000, 4'b0011, 4'b0000, 4'b0000, 4'b0011);
    add(1, 0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0011, 4'b0011);
    add(1, 0, 4'b0100, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    // reset after two counting cycles on ch0, button kept held
    add(4, 0, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(2, 1, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(5, 0, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1, 0, 4'b0101, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    add(1, 0, 4'b0101, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    add(5, 0, 4'b0100, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    add(1, 0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
    add(1, 0, 4'b0100, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    foreach (vecs[k]) begin
      rst_in = vecs[k].rst;
      btn_in = vecs[k].btn;
      clr_in = vecs[k].clr;
      exp_q.push_back({vecs[k].lvl, vecs[k].rise, vecs[k].fall, 4'b0000, vecs[k].pp});
      @(posedge clk_in);
      #1;
      check($sformatf("row%0d", k), {btn_out, rise_out, fall_out, repeat_out, press_pending_out},
            exp_q.pop_front());
    end
    // long hold on ch0: auto-repeat schedule, or no repeat at all in the default build
`ifdef BTN_DEBOUNCE_REPEAT_EN
    rep_q = '{20, 28, 36};
`endif
    rise_t = -1;
    rises = 0;
    btn_in = 4'b0101;
    for (int t = 0; t < 70; t++) begin
      if (rise_t >= 0 && t - rise_t == 38) btn_in = 4'b0100;
      @(posedge clk_in);
      #1;
      if (rise_out[0]) begin
        rises++;
        if (rise_t < 0) rise_t = t;
      end
`ifdef BTN_DEBOUNCE_REPEAT_EN
      if (repeat_out[0]) begin
        if (rep_q.size() == 0) check("repeat_extra", t - rise_t, 32'hffff_ffff);
        else check("repeat_offset", t - rise_t, rep_q.pop_front());
      end
`else
      check("repeat_off", repeat_out, 4'b0000);
`endif
    end
    check("hold_rise_latency", rise_t, 5);
    check("hold_rise_count", rises, 1);
    check("repeat_missing", rep_q.size(), 0);
    check("hold_released", btn_out, 4'b0000);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
